// File: rtl/dll_pkg.sv
// dll_pkg: shared state type and arithmetic helpers
// for the DLL lock controller and its slave scaling.
package dll_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_SAMPLE,
        S_TRACK
    } dll_state_e;

    function automatic logic [31:0] dll_sat_max(input int tap_w);
        return (32'd1 << tap_w) - 32'd1;
    endfunction

    // Slave tap = master * code / 2^ph_w, product kept to tap_w+ph_w bits.
    function automatic logic [31:0] dll_scale(
        input logic [31:0] sel,
        input logic [31:0] code,
        input int          tap_w,
        input int          ph_w
    );
        logic [31:0] prod;
        prod = (sel * code) & ((32'd1 << (tap_w + ph_w)) - 32'd1);
        return prod >> ph_w;
    endfunction

endpackage

// File: rtl/dll_lock_ctrl_if.sv
// dll_lock_ctrl_if: tap-select bus between the lock controller
// and the master/slave delay lines.
interface dll_lock_ctrl_if #(
    parameter int TAP_W = 7,
    parameter int N_CH  = 2,
    parameter int PH_W  = 4
);
    logic [N_CH*PH_W-1:0]  i_ph_code;
    logic [TAP_W-1:0]      o_master_sel;
    logic [N_CH*TAP_W-1:0] o_slave_sel;

    modport master (
        input  i_ph_code,
        output o_master_sel,
        output o_slave_sel
    );

    modport slave (
        output i_ph_code,
        input  o_master_sel,
        input  o_slave_sel
    );
endinterface

// File: rtl/dll_sync2.sv
// dll_sync2: generic two-flop synchroniser for asynchronous
// level inputs, shared across the PHY blocks.
module dll_sync2 #(
    parameter int W = 1
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);
    logic [W-1:0] r_meta;
    logic [W-1:0] r_sync;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;
endmodule

// File: rtl/dll_lock_ctrl.sv
// dll_lock_ctrl: binary-search DLL lock, hysteretic drift tracking
// and per-channel fractional slave tap generation.
module dll_lock_ctrl
    import dll_pkg::*;
#(
    parameter int TAP_W      = 7,
    parameter int N_CH       = 2,
    parameter int PH_W       = 4,
    parameter int SETTLE_CYC = 4,
    parameter int TRACK_INT  = 16,
    parameter int TRACK_HYST = 2
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_enable,
    input  logic            i_relock,
    input  logic            i_pd_late,
    dll_lock_ctrl_if.master bus,
    output logic            o_locked,
    output logic            o_busy,
    output logic            o_lock_err
);
    localparam int PTR_W = (TAP_W > 1) ? $clog2(TAP_W) : 1;
    localparam int CNT_W = $clog2(TRACK_INT + 1);
    localparam int RUN_W = $clog2(TRACK_HYST + 1);

    localparam logic [TAP_W-1:0] MID       = TAP_W'(1) << (TAP_W - 1);
    localparam logic [TAP_W-1:0] SAT_MAX   = TAP_W'(dll_sat_max(TAP_W));
    localparam logic [PTR_W-1:0] PTR_TOP   = PTR_W'(TAP_W - 1);
    localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] TRACK_LD  = CNT_W'(TRACK_INT - 1);
    localparam logic [RUN_W-1:0] HYST      = RUN_W'(TRACK_HYST);

    dll_state_e            r_state, w_state_nxt;
    logic [TAP_W-1:0]      r_master, w_master_nxt;
    logic [PTR_W-1:0]      r_ptr, w_ptr_nxt;
    logic [CNT_W-1:0]      r_cnt, w_cnt_nxt;
    logic [RUN_W-1:0]      r_run, w_run_nxt;
    logic                  r_dir, w_dir_nxt;
    logic                  r_locked, w_locked_nxt;
    logic                  r_busy, w_busy_nxt;
    logic                  r_err, w_err_nxt;
    logic [N_CH*TAP_W-1:0] r_slave;
    logic                  w_pd_late;
    logic                  w_start;
    logic [RUN_W-1:0]      w_run_inc;

    dll_sync2 #(.W(1)) u_pd_sync (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_d     (i_pd_late),
        .o_q     (w_pd_late)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_master_nxt = r_master;
        w_ptr_nxt    = r_ptr;
        w_cnt_nxt    = r_cnt;
        w_run_nxt    = r_run;
        w_dir_nxt    = r_dir;
        w_locked_nxt = r_locked;
        w_busy_nxt   = r_busy;
        w_err_nxt    = r_err;
        w_start      = 1'b0;
        w_run_inc    = (w_pd_late == r_dir) ? r_run + 1'b1 : RUN_W'(1);

        if (!i_enable) begin
            w_state_nxt  = S_IDLE;
            w_locked_nxt = 1'b0;
            w_busy_nxt   = 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: w_start = 1'b1;
                S_SETTLE: begin
                    if (r_cnt == '0) w_state_nxt = S_SAMPLE;
                    else             w_cnt_nxt   = r_cnt - 1'b1;
                end
                S_SAMPLE: begin
                    if (w_pd_late) w_master_nxt[r_ptr] = 1'b0;
                    if (r_ptr != '0) begin
                        w_master_nxt[r_ptr - 1'b1] = 1'b1;
                        w_ptr_nxt   = r_ptr - 1'b1;
                        w_cnt_nxt   = SETTLE_LD;
                        w_state_nxt = S_SETTLE;
                    end else begin
                        w_cnt_nxt   = TRACK_LD;
                        w_run_nxt   = '0;
                        w_dir_nxt   = 1'b0;
                        w_state_nxt = S_TRACK;
                    end
                end
                S_TRACK: begin
                    if (i_relock) begin
                        w_start = 1'b1;
                    end else begin
                        // Lock is announced on the first tracking cycle.
                        if (r_busy) begin
                            w_busy_nxt   = 1'b0;
                            w_locked_nxt = 1'b1;
                        end
                        if (r_cnt != '0) begin
                            w_cnt_nxt = r_cnt - 1'b1;
                        end else begin
                            w_cnt_nxt = TRACK_LD;
                            w_dir_nxt = w_pd_late;
                            w_run_nxt = w_run_inc;
                            if (w_run_inc == HYST) begin
                                w_run_nxt = '0;
                                if (w_pd_late ? (r_master == '0)
                                              : (r_master == SAT_MAX)) begin
                                    w_err_nxt    = 1'b1;
                                    w_locked_nxt = 1'b0;
                                end else if (w_pd_late) begin
                                    w_master_nxt = r_master - 1'b1;
                                end else begin
                                    w_master_nxt = r_master + 1'b1;
                                end
                            end
                        end
                    end
                end
            endcase
        end

        if (w_start) begin
            w_master_nxt = MID;
            w_ptr_nxt    = PTR_TOP;
            w_cnt_nxt    = SETTLE_LD;
            w_run_nxt    = '0;
            w_dir_nxt    = 1'b0;
            w_busy_nxt   = 1'b1;
            w_locked_nxt = 1'b0;
            w_err_nxt    = 1'b0;
            w_state_nxt  = S_SETTLE;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_master <= '0;
            r_ptr    <= '0;
            r_cnt    <= '0;
            r_run    <= '0;
            r_dir    <= 1'b0;
            r_locked <= 1'b0;
            r_busy   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_master <= w_master_nxt;
            r_ptr    <= w_ptr_nxt;
            r_cnt    <= w_cnt_nxt;
            r_run    <= w_run_nxt;
            r_dir    <= w_dir_nxt;
            r_locked <= w_locked_nxt;
            r_busy   <= w_busy_nxt;
            r_err    <= w_err_nxt;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_slave <= '0;
        end else begin
            for (int k = 0; k < N_CH; k++) begin
                r_slave[k*TAP_W +: TAP_W] <= TAP_W'(dll_scale(
                    32'(r_master),
                    32'(bus.i_ph_code[k*PH_W +: PH_W]),
                    TAP_W, PH_W));
            end
        end
    end

    assign bus.o_master_sel = r_master;
    assign bus.o_slave_sel  = r_slave;
    assign o_locked         = r_locked;
    assign o_busy           = r_busy;
    assign o_lock_err       = r_err;
endmodule

// File: tb/tb_dll_lock_ctrl.sv
// tb_dll_lock_ctrl: directed and randomized checks of search, tracking,
// relock, saturation, enable/reset and slave scaling.
module tb_dll_lock_ctrl;
    localparam int TAP_W = 7;
    localparam int N_CH  = 2;
    localparam int PH_W  = 4;

    logic clk    = 1'b0;
    logic rst_n  = 1'b0;
    logic enable = 1'b0;
    logic relock = 1'b0;
    logic pd_late;
    logic locked, busy, lock_err;
    int   thr    = 0;
    int   n_cmp  = 0;
    int   n_fail = 0;

    dll_lock_ctrl_if #(.TAP_W(TAP_W), .N_CH(N_CH), .PH_W(PH_W)) bus ();

    dll_lock_ctrl dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_enable   (enable),
        .i_relock   (relock),
        .i_pd_late  (pd_late),
        .bus        (bus),
        .o_locked   (locked),
        .o_busy     (busy),
        .o_lock_err (lock_err)
    );

    always #5 clk = ~clk;

    // Ideal line: late whenever the selected delay exceeds the period.
    assign pd_late = (int'(bus.o_master_sel) > thr);

    // Tap tried at step j of a successive-approximation search (j=TAP_W: result).
    function automatic int srch(int t, int j);
        int m = 0;
        int c;
        for (int b = TAP_W - 1; b >= 0; b--) begin
            c = m | (1 << b);
            if (TAP_W - 1 - b == j) return c;
            if (c <= t) m = c;
        end
        return m;
    endfunction

    function automatic int slv(int m, int c0, int c1);
        return (((m * c1) / 16) << TAP_W) | ((m * c0) / 16);
    endfunction

    task automatic tick(int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    int k, c0, c1, cnt, prev, want;
    bit ok;

    initial begin
        bus.i_ph_code = '0;
        tick(2);
        chk("rst_master", bus.o_master_sel, 0);
        chk("rst_slave", bus.o_slave_sel, 0);
        chk("rst_locked", locked, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", lock_err, 0);
        rst_n = 1'b1;
        tick(2);
        chk("idle_busy", busy, 0);

        // Directed search to 45 with codes {4,8}.
        thr = 45;
        bus.i_ph_code = {4'd8, 4'd4};
        enable = 1'b1;
        for (int i = 1; i <= 36; i++) begin
            tick();
            chk($sformatf("search_k%0d", i), bus.o_master_sel, srch(45, (i - 1) / 5));
            if (i == 1) chk("search_busy", busy, 1);
        end
        chk("search_locked_early", locked, 0);
        tick();
        chk("search_locked", locked, 1);
        chk("search_busy_done", busy, 0);
        chk("search_slave", bus.o_slave_sel, slv(45, 4, 8));

        // Drift up to 50, then dither 50/51 every 32 cycles.
        thr = 50;
        ok = 1;
        cnt = 0;
        while (int'(bus.o_master_sel) != 50 && cnt < 400) begin
            tick();
            cnt++;
            if (locked !== 1'b1) ok = 0;
        end
        chk("drift_reach", bus.o_master_sel, 50);
        prev = 50;
        for (int i = 0; i < 4; i++) begin
            want = (i % 2 == 0) ? 51 : 50;
            cnt = 0;
            while (int'(bus.o_master_sel) == prev && cnt < 40) begin
                tick();
                cnt++;
                if (locked !== 1'b1) ok = 0;
            end
            chk($sformatf("drift_int%0d", i), cnt, 32);
            chk($sformatf("drift_val%0d", i), bus.o_master_sel, want);
            prev = want;
        end
        chk("drift_locked", ok, 1);

        // Relock to 20; a second pulse during SETTLE must be ignored.
        thr = 20;
        relock = 1'b1;
        tick();
        relock = 1'b0;
        chk("relock_busy", busy, 1);
        chk("relock_unlocked", locked, 0);
        relock = 1'b1;
        tick();
        relock = 1'b0;
        tick(4);
        chk("relock_step1", bus.o_master_sel, srch(20, 1));
        tick(30);
        chk("relock_early", locked, 0);
        tick();
        chk("relock_locked", locked, 1);
        chk("relock_master", bus.o_master_sel, 20);

        // Saturation at the top tap.
        thr = 200;
        relock = 1'b1;
        tick();
        relock = 1'b0;
        tick(36);
        chk("sat_locked", locked, 1);
        chk("sat_search", bus.o_master_sel, 127);
        cnt = 0;
        while (lock_err !== 1'b1 && cnt < 40) begin
            tick();
            cnt++;
        end
        chk("sat_err", lock_err, 1);
        chk("sat_unlocked", locked, 0);
        chk("sat_master", bus.o_master_sel, 127);
        tick(40);
        chk("sat_hold", bus.o_master_sel, 127);
        chk("sat_err_hold", lock_err, 1);

        // Scaling edges: code 15 and code 0 at master 127.
        bus.i_ph_code = {4'd0, 4'd15};
        tick();
        chk("scale_edge", bus.o_slave_sel, slv(127, 15, 0));

        // Enable drop from TRACK keeps sel and sticky error.
        enable = 1'b0;
        tick();
        chk("dis_locked", locked, 0);
        chk("dis_busy", busy, 0);
        chk("dis_err", lock_err, 1);
        chk("dis_master", bus.o_master_sel, 127);

        // Enable drop mid-search.
        thr = $urandom_range(0, 127);
        bus.i_ph_code = PH_W * N_CH'($urandom);
        enable = 1'b1;
        tick();
        chk("mid_err_clr", lock_err, 0);
        chk("mid_busy", busy, 1);
        k = $urandom_range(3, 30);
        tick(k - 1);
        enable = 1'b0;
        tick();
        chk("mid_master", bus.o_master_sel, srch(thr, (k - 1) / 5));
        chk("mid_busy_off", busy, 0);
        tick(5);
        chk("mid_master_hold", bus.o_master_sel, srch(thr, (k - 1) / 5));

        // Asynchronous reset mid-search.
        enable = 1'b1;
        tick(12);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_master", bus.o_master_sel, 0);
        chk("arst_slave", bus.o_slave_sel, 0);
        chk("arst_busy", busy, 0);
        chk("arst_locked", locked, 0);
        enable = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(3);
        chk("arst_idle", bus.o_master_sel, 0);

        // Randomized locks.
        for (int it = 0; it < 6; it++) begin
            thr = $urandom_range(0, 150);
            c0 = $urandom_range(0, 15);
            c1 = $urandom_range(0, 15);
            bus.i_ph_code = {c1[3:0], c0[3:0]};
            enable = 1'b1;
            tick(36);
            chk($sformatf("rnd%0d_early", it), locked, 0);
            tick();
            want = (thr > 127) ? 127 : thr;
            chk($sformatf("rnd%0d_locked", it), locked, 1);
            chk($sformatf("rnd%0d_master", it), bus.o_master_sel, want);
            chk($sformatf("rnd%0d_slave", it), bus.o_slave_sel, slv(want, c0, c1));
            enable = 1'b0;
            tick();
            chk($sformatf("rnd%0d_off", it), locked, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
